adc_scan_scheduler: RTL and testbench
=====================================

ADC_SCAN_SCHEDULER -- requirements
Module: adc_scan_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of ADC channels (2..8).
REQ-002 SHALL have parameter PERIOD, default 1000, clk cycles between scan ticks (>= 16).
REQ-003 SHALL have parameter TIMEOUT, default 255, max clk cycles waiting for spi_done.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  scan enable.
REQ-007 SHALL have port ch_mask  input  NUM_CH  enabled channels, bit i = channel i.
REQ-008 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-009 SHALL have port spi_busy  input  1  SPI engine busy.
REQ-010 SHALL have port spi_done  input  1  one-cycle pulse, spi_data valid.
REQ-011 SHALL have port spi_data  input  12  conversion result.
REQ-012 SHALL have port spi_start  output  1  one-cycle transaction request.
REQ-013 SHALL have port spi_ch  output  clog2(NUM_CH)  channel for current transaction.
REQ-014 SHALL have port smp_valid  output  1  one-cycle pulse, new sample.
REQ-015 SHALL have port smp_ch  output  clog2(NUM_CH)  channel of sample.
REQ-016 SHALL have port smp_data  output  12  sample value.
REQ-017 SHALL have port scan_done  output  1  one-cycle pulse at end of a scan.
REQ-018 SHALL have port timeout_err  output  1  sticky, a transaction timed out.
REQ-019 SHALL have port overrun_err  output  1  sticky, tick arrived during a scan.

Function
REQ-020 SHALL run a period counter 0..PERIOD-1 while en=1, held at 0 while en=0; internal tick when count = PERIOD-1, so the first tick occurs PERIOD cycles after en rises.
REQ-021 SHALL implement states IDLE, WAIT_TICK, START, WAIT_DONE, NEXT.
REQ-022 IDLE -> WAIT_TICK when en=1.
REQ-023 WAIT_TICK on tick: latch ch_mask; mask nonzero -> spi_ch = lowest set bit, go START; mask zero -> stay, no scan_done.
REQ-024 START: when spi_busy=0, pulse spi_start one cycle, clear timeout counter, go WAIT_DONE; while spi_busy=1, wait with spi_start=0.
REQ-025 Latency: tick in cycle T with spi_busy=0 -> spi_start high in cycle T+1.
REQ-026 spi_ch SHALL remain stable from spi_start until leaving WAIT_DONE.
REQ-027 WAIT_DONE: spi_done in cycle D -> smp_data=spi_data, smp_ch=spi_ch, smp_valid=1 in cycle D+1; go NEXT.
REQ-028 WAIT_DONE: TIMEOUT cycles after spi_start with no spi_done -> set timeout_err, no smp_valid, go NEXT.
REQ-029 NEXT: select next higher set bit of latched mask -> START (earliest next spi_start D+2); none left -> scan_done pulse, go WAIT_TICK.
REQ-030 Tick while in START, WAIT_DONE or NEXT SHALL set overrun_err and be dropped; the scan in progress continues.
REQ-031 en=0 in WAIT_TICK or START -> IDLE next cycle, no spi_start; en=0 in WAIT_DONE -> complete transaction (sample or timeout) then IDLE, no scan_done.
REQ-032 Changes to ch_mask mid-scan SHALL take effect only at the next tick.
REQ-033 err_clr=1 clears timeout_err and overrun_err; a set event in the same cycle wins.
REQ-034 smp_data, smp_ch SHALL hold last value between smp_valid pulses.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE, counters 0, latched mask 0, spi_start=0, spi_ch=0, smp_valid=0, smp_ch=0, smp_data=0, scan_done=0, timeout_err=0, overrun_err=0.
REQ-036 Reset mid-transaction SHALL abandon it; a late spi_done after release SHALL be ignored unless in WAIT_DONE.

Verification
REQ-037 PERIOD=20, mask=4'b1010, SPI model done 5 cycles after start, data=12'hABC/12'h123 -> spi_start ch1 at T+1, smp_valid ch1=ABC, then ch3=123, one scan_done.
REQ-038 mask=0, en=1 for 3 periods -> no spi_start, no scan_done, no errors.
REQ-039 SPI model never pulses done, TIMEOUT=10 -> timeout_err at start+10, no smp_valid, next channel started; err_clr clears flag.
REQ-040 SPI latency 30 > PERIOD=20 -> overrun_err set, scan completes all enabled channels.
REQ-041 spi_busy held 7 cycles at tick -> spi_start delayed until busy low, exactly one pulse.
REQ-042 rst_n low during WAIT_DONE, spi_done after release -> all outputs at reset values, no smp_valid.

Source files
------------

// File: rtl/adc_scan_scheduler.sv
// ADC scan scheduler: on every period tick walks the enabled channels of an
// external SPI ADC one transaction at a time, reporting samples and error flags.
module adc_scan_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic                      err_clr,
    input  logic                      spi_busy,
    input  logic                      spi_done,
    input  logic [11:0]               spi_data,
    output logic                      spi_start,
    output logic [$clog2(NUM_CH)-1:0] spi_ch,
    output logic                      smp_valid,
    output logic [$clog2(NUM_CH)-1:0] smp_ch,
    output logic [11:0]               smp_data,
    output logic                      scan_done,
    output logic                      timeout_err,
    output logic                      overrun_err
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(PERIOD);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, START, WAIT_DONE, NEXT} state_t;

    // Returns {found, index} of the lowest set mask bit (from_zero) or of the
    // lowest set bit strictly above cur.
    function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] mask,
                                              input logic [CH_W-1:0]   cur,
                                              input logic              from_zero);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_zero || i > int'(cur))) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              abort_q, abort_d;
    logic              smp_valid_q, smp_valid_d;
    logic [CH_W-1:0]   smp_ch_q, smp_ch_d;
    logic [11:0]       smp_data_q, smp_data_d;
    logic              scan_done_q, scan_done_d;
    logic              tmo_err_q, tmo_err_d;
    logic              ovr_err_q, ovr_err_d;
    logic              tick, expired, tmo_evt, ovr_evt;
    logic [CH_W:0]     sel;

    assign tick    = en && (cnt_q == CNT_LAST);
    // tmo_q counts cycles elapsed since spi_start (the start cycle is cycle 0)
    assign expired = (tmo_q >= TMO_LAST);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ch_d        = ch_q;
        tmo_d       = tmo_q;
        abort_d     = abort_q;
        smp_valid_d = 1'b0;
        smp_ch_d    = smp_ch_q;
        smp_data_d  = smp_data_q;
        scan_done_d = 1'b0;
        spi_start   = 1'b0;
        tmo_evt     = 1'b0;
        sel         = '0;
        cnt_d       = (en && !tick) ? cnt_q + CNT_W'(1) : '0;
        ovr_evt     = tick && (state_q == START || state_q == WAIT_DONE || state_q == NEXT);

        case (state_q)
            IDLE: begin
                if (en) state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (tick) begin
                    mask_d = ch_mask;
                    sel    = find_ch(ch_mask, '0, 1'b1);
                    if (sel[CH_W]) begin
                        ch_d    = sel[CH_W-1:0];
                        state_d = START;
                    end
                end
            end
            START: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (!spi_busy) begin
                    spi_start = 1'b1;
                    tmo_d     = TMO_W'(1);
                    abort_d   = 1'b0;
                    state_d   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A disable here is remembered so the transaction still finishes
                if (!en) abort_d = 1'b1;
                if (spi_done) begin
                    smp_valid_d = 1'b1;
                    smp_data_d  = spi_data;
                    smp_ch_d    = ch_q;
                end else if (expired) begin
                    tmo_evt = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                if (spi_done || expired) state_d = (!en || abort_q) ? IDLE : NEXT;
            end
            NEXT: begin
                sel = find_ch(mask_q, ch_q, 1'b0);
                if (!en) begin
                    state_d = IDLE;
                end else if (sel[CH_W]) begin
                    ch_d    = sel[CH_W-1:0];
                    state_d = START;
                end else begin
                    scan_done_d = 1'b1;
                    state_d     = WAIT_TICK;
                end
            end
            default: state_d = IDLE;
        endcase

        tmo_err_d = tmo_evt | (tmo_err_q & ~err_clr);
        ovr_err_d = ovr_evt | (ovr_err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            mask_q      <= '0;
            ch_q        <= '0;
            abort_q     <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_ch_q    <= '0;
            smp_data_q  <= '0;
            scan_done_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            abort_q     <= abort_d;
            smp_valid_q <= smp_valid_d;
            smp_ch_q    <= smp_ch_d;
            smp_data_q  <= smp_data_d;
            scan_done_q <= scan_done_d;
            tmo_err_q   <= tmo_err_d;
            ovr_err_q   <= ovr_err_d;
        end
    end

    assign spi_ch      = ch_q;
    assign smp_valid   = smp_valid_q;
    assign smp_ch      = smp_ch_q;
    assign smp_data    = smp_data_q;
    assign scan_done   = scan_done_q;
    assign timeout_err = tmo_err_q;
    assign overrun_err = ovr_err_q;
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler: SPI responder model plus a sample
// scoreboard; a second instance with a long timeout covers slow-SPI overrun.
module tb_adc_scan_scheduler;
    typedef struct packed { logic [1:0] ch; logic [11:0] data; } smp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, err_clr, spi_busy, spi_done;
    logic [3:0]  ch_mask;
    logic [11:0] spi_data;
    logic        spi_start, smp_valid, scan_done, timeout_err, overrun_err;
    logic [1:0]  spi_ch, smp_ch;
    logic [11:0] smp_data;

    logic        en_b, busy_b, done_b;
    logic [11:0] data_b;
    logic        start_b, valid_b, scandone_b, tmo_b, ovr_b;
    logic [1:0]  ch_b, smpch_b;
    logic [11:0] smpdata_b;

    adc_scan_scheduler #(.NUM_CH(4), .PERIOD(20), .TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask), .err_clr(err_clr),
        .spi_busy(spi_busy), .spi_done(spi_done), .spi_data(spi_data),
        .spi_start(spi_start), .spi_ch(spi_ch), .smp_valid(smp_valid), .smp_ch(smp_ch),
        .smp_data(smp_data), .scan_done(scan_done), .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    adc_scan_scheduler #(.NUM_CH(4), .PERIOD(20), .TIMEOUT(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .ch_mask(ch_mask), .err_clr(err_clr),
        .spi_busy(busy_b), .spi_done(done_b), .spi_data(data_b),
        .spi_start(start_b), .spi_ch(ch_b), .smp_valid(valid_b), .smp_ch(smpch_b),
        .smp_data(smpdata_b), .scan_done(scandone_b), .timeout_err(tmo_b),
        .overrun_err(ovr_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_start = 0, n_scan = 0, start_cyc = 0;
    int n_start_b = 0, n_scan_b = 0, start_cyc_b = 0;
    int mdl_lat = 0;
    logic [11:0] tbl [4];
    logic [1:0]  exp_ch [$];
    smp_t        sb [$];
    smp_t        sb_b [$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed no finish by 50000, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int evt_cnt(input int which);
        case (which)
            0:       return n_start;
            1:       return n_scan;
            2:       return n_start_b;
            default: return n_scan_b;
        endcase
    endfunction

    task automatic wait_evt(input string tag, input int which, input int target);
        int k;
        k = 0;
        while (evt_cnt(which) < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(evt_cnt(which) >= target), 32'd1);
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic neg_at(input int c);
        step_to(c);
        @(negedge clk);
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({spi_start, spi_ch, smp_valid, smp_ch, smp_data, scan_done,
                    timeout_err, overrun_err});
    endfunction

    // SPI responder for dut (done mdl_lat cycles after start, 0 = never) and
    // output monitors for both instances.
    initial begin
        int   cnt;
        bit   pend;
        logic [1:0] pch;
        smp_t ex;
        spi_done = 1'b0;
        spi_data = '0;
        pend     = 1'b0;
        cnt      = 0;
        pch      = '0;
        forever begin
            @(posedge clk);
            #1;
            spi_done = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    spi_done = 1'b1;
                    spi_data = tbl[pch];
                    pend     = 1'b0;
                end
            end
            @(negedge clk);
            if (spi_start) begin
                n_start++;
                start_cyc = cyc;
                tests++;
                assert (exp_ch.size() > 0) else begin
                    fails++;
                    $error("FAIL start_unexp: observed spi_start ch %0d expected none", spi_ch);
                end
                if (exp_ch.size() > 0) chk("start_ch", 32'(spi_ch), 32'(exp_ch.pop_front()));
                if (mdl_lat > 0) begin
                    pend = 1'b1;
                    cnt  = mdl_lat;
                    pch  = spi_ch;
                end
            end
            if (smp_valid) begin
                tests++;
                assert (sb.size() > 0) else begin
                    fails++;
                    $error("FAIL smp_unexp: observed ch %0d data %0h expected none", smp_ch, smp_data);
                end
                if (sb.size() > 0) begin
                    ex = sb.pop_front();
                    chk("smp_ch", 32'(smp_ch), 32'(ex.ch));
                    chk("smp_data", 32'(smp_data), 32'(ex.data));
                end
            end
            if (scan_done) n_scan++;
            if (start_b) begin
                n_start_b++;
                start_cyc_b = cyc;
            end
            if (valid_b) begin
                tests++;
                assert (sb_b.size() > 0) else begin
                    fails++;
                    $error("FAIL smp_b_unexp: observed ch %0d data %0h expected none", smpch_b, smpdata_b);
                end
                if (sb_b.size() > 0) begin
                    ex = sb_b.pop_front();
                    chk("smp_b_ch", 32'(smpch_b), 32'(ex.ch));
                    chk("smp_b_data", 32'(smpdata_b), 32'(ex.data));
                end
            end
            if (scandone_b) n_scan_b++;
        end
    end

    initial begin
        int e, s0, d0, s1, s2;
        rst_n = 1'b0; en = 1'b0; ch_mask = '0; err_clr = 1'b0; spi_busy = 1'b0;
        en_b = 1'b0; busy_b = 1'b0; done_b = 1'b0; data_b = '0;
        tbl[0] = 12'h5E7; tbl[1] = 12'hABC; tbl[2] = 12'h777; tbl[3] = 12'h123;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", out_vec(), 32'd0);
        chk("rst_b_errs", 32'({tmo_b, ovr_b, valid_b, start_b}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two-channel scan, mask change mid-scan must be ignored
        mdl_lat = 5;
        ch_mask = 4'b1010;
        exp_ch.push_back(2'd1);
        exp_ch.push_back(2'd3);
        sb.push_back('{ch: 2'd1, data: 12'hABC});
        sb.push_back('{ch: 2'd3, data: 12'h123});
        s0 = n_start; d0 = n_scan;
        en = 1'b1;
        e  = cyc;
        wait_evt("t1_start1", 0, s0 + 1);
        s1 = start_cyc;
        chk("t1_latency", 32'(s1), 32'(e + 20));
        @(posedge clk);
        #1;
        ch_mask = 4'b0001;
        wait_evt("t1_start2", 0, s0 + 2);
        chk("t1_next_gap", 32'(start_cyc), 32'(s1 + 7));
        wait_evt("t1_scan", 1, d0 + 1);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_starts", 32'(n_start), 32'(s0 + 2));
        chk("t1_scans", 32'(n_scan), 32'(d0 + 1));
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);
        chk("t1_hold_ch", 32'(smp_ch), 32'd3);
        chk("t1_hold_data", 32'(smp_data), 32'h123);
        chk("t1_errs", 32'({timeout_err, overrun_err}), 32'd0);

        // Empty mask for three periods
        ch_mask = 4'b0000;
        s0 = n_start; d0 = n_scan;
        @(posedge clk);
        #1;
        en = 1'b1;
        repeat (65) @(posedge clk);
        #1;
        en = 1'b0;
        @(negedge clk);
        chk("t2_no_start", 32'(n_start), 32'(s0));
        chk("t2_no_scan", 32'(n_scan), 32'(d0));
        chk("t2_errs", 32'({timeout_err, overrun_err}), 32'd0);

        // SPI never answers: timeouts, next channel still started
        mdl_lat = 0;
        ch_mask = 4'b0101;
        exp_ch.push_back(2'd0);
        exp_ch.push_back(2'd2);
        s0 = n_start; d0 = n_scan;
        @(posedge clk);
        #1;
        en = 1'b1;
        e  = cyc;
        wait_evt("t3_start1", 0, s0 + 1);
        s1 = start_cyc;
        chk("t3_latency", 32'(s1), 32'(e + 20));
        neg_at(s1 + 9);
        chk("t3_tmo_early", 32'(timeout_err), 32'd0);
        neg_at(s1 + 10);
        chk("t3_tmo_set", 32'(timeout_err), 32'd1);
        wait_evt("t3_start2", 0, s0 + 2);
        chk("t3_next", 32'(start_cyc), 32'(s1 + 11));
        wait_evt("t3_scan", 1, d0 + 1);
        @(posedge clk);
        #1;
        en = 1'b0;
        @(negedge clk);
        chk("t3_sticky", 32'({timeout_err, overrun_err}), 32'b11);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("t3_cleared", 32'({timeout_err, overrun_err}), 32'd0);

        // spi_busy held across the tick delays the start
        mdl_lat = 3;
        ch_mask = 4'b0001;
        exp_ch.push_back(2'd0);
        sb.push_back('{ch: 2'd0, data: 12'h5E7});
        s0 = n_start; d0 = n_scan;
        @(posedge clk);
        #1;
        en = 1'b1;
        e  = cyc;
        step_to(e + 17);
        spi_busy = 1'b1;
        step_to(e + 24);
        chk("t4_held", 32'(n_start), 32'(s0));
        spi_busy = 1'b0;
        wait_evt("t4_start", 0, s0 + 1);
        chk("t4_latency", 32'(start_cyc), 32'(e + 24));
        wait_evt("t4_scan", 1, d0 + 1);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_one_start", 32'(n_start), 32'(s0 + 1));

        // Reset during WAIT_DONE, late spi_done after release
        mdl_lat = 8;
        exp_ch.push_back(2'd0);
        s0 = n_start;
        @(posedge clk);
        #1;
        en = 1'b1;
        wait_evt("t5_start", 0, s0 + 1);
        s1 = start_cyc;
        step_to(s1 + 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_now", out_vec(), 32'd0);
        step_to(s1 + 5);
        rst_n = 1'b1;
        neg_at(s1 + 9);
        chk("t5_after_late", out_vec(), 32'd0);
        step_to(s1 + 12);
        en = 1'b0;
        @(negedge clk);
        chk("t5_starts", 32'(n_start), 32'(s0 + 1));

        // Slow SPI (30 cycles) on the long-timeout instance: overrun, scan completes
        ch_mask = 4'b0011;
        sb_b.push_back('{ch: 2'd0, data: 12'h5A5});
        sb_b.push_back('{ch: 2'd1, data: 12'h3C3});
        @(posedge clk);
        #1;
        en_b = 1'b1;
        e    = cyc;
        wait_evt("t6_start1", 2, 1);
        s1 = start_cyc_b;
        chk("t6_latency", 32'(s1), 32'(e + 20));
        chk("t6_ch0", 32'(ch_b), 32'd0);
        step_to(s1 + 30);
        done_b = 1'b1;
        data_b = 12'h5A5;
        step_to(s1 + 31);
        done_b = 1'b0;
        @(negedge clk);
        chk("t6_overrun", 32'(ovr_b), 32'd1);
        wait_evt("t6_start2", 2, 2);
        s2 = start_cyc_b;
        chk("t6_next", 32'(s2), 32'(s1 + 32));
        chk("t6_ch1", 32'(ch_b), 32'd1);
        step_to(s2 + 30);
        done_b = 1'b1;
        data_b = 12'h3C3;
        step_to(s2 + 31);
        done_b = 1'b0;
        wait_evt("t6_scan", 3, 1);
        @(posedge clk);
        #1;
        en_b = 1'b0;
        @(negedge clk);
        chk("t6_no_tmo", 32'(tmo_b), 32'd0);
        chk("t6_starts", 32'(n_start_b), 32'd2);
        chk("t6_sb_empty", 32'(sb_b.size()), 32'd0);

        chk("end_exp_ch_empty", 32'(exp_ch.size()), 32'd0);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
